mem_stage: RTL and testbench

- Memory-access stage; sits between the EX/MEM pipeline register and the MEM/WB register.
- Converts load/store requests into a single-outstanding req/gnt/rvalid data-bus transaction, with byte-lane alignment.
- Returns loads sign- or zero-extended. Passes ALU and CSR results through untouched.
- Raises a stall request to flow control while a transaction is in flight; flags misaligned, bus-error and timeout accesses.

---
 rtl/core_defs_pkg.sv | 33 +++
 rtl/mem_lane_align.sv | 67 ++++++
 rtl/mem_stage.sv | 212 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_defs_pkg.sv
// Shared definitions for the core's memory-access path: width/rw codes,
// memory stage state encoding and exception codes.
package core_defs_pkg;

  localparam logic [1:0] MW_BYTE = 2'b00;
  localparam logic [1:0] MW_HALF = 2'b01;
  localparam logic [1:0] MW_WORD = 2'b10;
  localparam logic [1:0] MW_ILL  = 2'b11;

  localparam logic RW_LOAD  = 1'b0;
  localparam logic RW_STORE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_ALIGN   = 2'b01;
  localparam logic [1:0] EXC_BUS     = 2'b10;
  localparam logic [1:0] EXC_TIMEOUT = 2'b11;

  // Illegal width code or an address not naturally aligned to the width.
  function automatic logic mem_access_bad(input logic [1:0] width,
                                          input logic [1:0] addr_lo);
    return (width == MW_ILL) ||
           ((width == MW_HALF) && addr_lo[0]) ||
           ((width == MW_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment for a 32-bit data bus: store byte enables and lane
// replication, load lane extraction with sign/zero extension.
module mem_lane_align
  import core_defs_pkg::*;
(
  input  logic        is_store,
  input  logic [1:0]  width,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  input  logic        rd_zext,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  function automatic logic [31:0] ext8(input logic [7:0] v, input logic zext);
    logic signed [7:0]  s;
    logic signed [31:0] w;
    s = signed'(v);
    w = s;
    return zext ? {24'd0, v} : w;
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] v, input logic zext);
    logic signed [15:0] s;
    logic signed [31:0] w;
    s = signed'(v);
    w = s;
    return zext ? {16'd0, v} : w;
  endfunction

  logic [31:0] sh;

  // Store side: byte enables follow the address, data is replicated on every lane.
  always_comb begin
    be    = 4'b1111;
    wdata = '0;
    if (is_store) begin
      case (width)
        MW_BYTE: begin
          be    = 4'b0001 << addr_lo;
          wdata = {4{st_data[7:0]}};
        end
        MW_HALF: begin
          be    = 4'b0011 << addr_lo;
          wdata = {2{st_data[15:0]}};
        end
        default: begin
          be    = 4'b1111;
          wdata = st_data;
        end
      endcase
    end
  end

  // Load side: shift the addressed lane down to bit 0, then extend.
  always_comb begin
    sh = rdata >> {addr_lo, 3'b000};
    case (width)
      MW_BYTE: ld_data = ext8(sh[7:0], rd_zext);
      MW_HALF: ld_data = ext16(sh[15:0], rd_zext);
      default: ld_data = sh;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: turns EX/MEM load/store requests into a single
// outstanding req/gnt/rvalid bus transaction, stalls upstream while it is in
// flight, and forwards ALU/CSR results to MEM/WB.
module mem_stage
  import core_defs_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] exmem_reg_wdata_i,
  input  logic [4:0]  exmem_reg_waddr_i,
  input  logic        exmem_reg_we_i,
  input  logic [31:0] exmem_csr_wdata_i,
  input  logic [11:0] exmem_csr_waddr_i,
  input  logic        exmem_csr_we_i,
  input  logic        exmem_mtype_i,
  input  logic        exmem_mem_rw_i,
  input  logic [1:0]  exmem_mem_width_i,
  input  logic [31:0] exmem_mem_addr_i,
  input  logic        exmem_mem_rdtype_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic [31:0] mem_reg_wdata_o,
  output logic [4:0]  mem_reg_waddr_o,
  output logic        mem_reg_we_o,
  output logic [31:0] mem_csr_wdata_o,
  output logic [11:0] mem_csr_waddr_o,
  output logic        mem_csr_we_o,
  output logic        mem_stall_req_o,
  output logic        mem_exc_o,
  output logic [1:0]  mem_exc_code_o
);

  mem_state_e  state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] timer_q, timer_d;

  logic        bad;
  logic        go;
  logic        is_store;
  logic [31:0] tmo_cnt;
  logic        tmo_hit;

  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_ld;

  logic        req_c;
  logic        stall_c;
  logic        exc_c;
  logic [1:0]  code_c;
  logic [31:0] reg_wdata_c;
  logic        reg_we_c;
  logic        csr_we_c;

  assign bad      = exmem_mtype_i & mem_access_bad(exmem_mem_width_i, exmem_mem_addr_i[1:0]);
  assign go       = exmem_mtype_i & ~bad;
  assign is_store = (exmem_mem_rw_i == RW_STORE);

  // The cycle that issues the request from IDLE counts as request cycle zero,
  // so the watchdog bounds the total number of stall cycles.
  assign tmo_cnt = (state_q == ST_IDLE) ? 32'd0 : timer_q;
  assign tmo_hit = (TIMEOUT_CYC != 0) && (tmo_cnt >= TIMEOUT_CYC - 1);

  mem_lane_align u_align (
    .is_store (is_store),
    .width    (exmem_mem_width_i),
    .addr_lo  (exmem_mem_addr_i[1:0]),
    .st_data  (exmem_reg_wdata_i),
    .rdata    (rdata_q),
    .rd_zext  (exmem_mem_rdtype_i),
    .be       (lane_be),
    .wdata    (lane_wdata),
    .ld_data  (lane_ld)
  );

  // State, captured response and watchdog registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
      err_q   <= EXC_NONE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

  // Next-state: bus handshake progress, response capture and watchdog abort.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        err_d   = EXC_NONE;
        if (go) begin
          timer_d = 32'd1;
          if (mem_gnt_i) begin
            state_d = ST_WAIT;
          end else if (tmo_hit) begin
            state_d = ST_DONE;
            err_d   = EXC_TIMEOUT;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        timer_d = timer_q + 32'd1;
        if (mem_gnt_i) begin
          state_d = ST_WAIT;
        end else if (tmo_hit) begin
          state_d = ST_DONE;
          err_d   = EXC_TIMEOUT;
        end
      end
      ST_WAIT: begin
        timer_d = timer_q + 32'd1;
        if (mem_rvalid_i) begin
          state_d = ST_DONE;
          rdata_d = mem_rdata_i;
          err_d   = mem_err_i ? EXC_BUS : EXC_NONE;
        end else if (tmo_hit) begin
          state_d = ST_DONE;
          err_d   = EXC_TIMEOUT;
        end
      end
      default: begin
        timer_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs: request/stall per state, result selection and write-enable gating.
  always_comb begin
    req_c       = 1'b0;
    stall_c     = 1'b0;
    exc_c       = 1'b0;
    code_c      = EXC_NONE;
    reg_wdata_c = exmem_reg_wdata_i;
    reg_we_c    = exmem_reg_we_i;
    csr_we_c    = exmem_csr_we_i;
    case (state_q)
      ST_IDLE: begin
        if (bad) begin
          exc_c    = 1'b1;
          code_c   = EXC_ALIGN;
          reg_we_c = 1'b0;
          csr_we_c = 1'b0;
        end else if (go) begin
          req_c    = 1'b1;
          stall_c  = 1'b1;
          reg_we_c = 1'b0;
          csr_we_c = 1'b0;
        end
      end
      ST_REQ: begin
        req_c    = 1'b1;
        stall_c  = 1'b1;
        reg_we_c = 1'b0;
        csr_we_c = 1'b0;
      end
      ST_WAIT: begin
        stall_c  = 1'b1;
        reg_we_c = 1'b0;
        csr_we_c = 1'b0;
      end
      default: begin
        if (!is_store) reg_wdata_c = lane_ld;
        if (err_q != EXC_NONE) begin
          exc_c    = 1'b1;
          code_c   = err_q;
          reg_we_c = 1'b0;
          csr_we_c = 1'b0;
        end
      end
    endcase
  end

  assign mem_req_o       = rst_n & req_c;
  assign mem_we_o        = rst_n & req_c & is_store;
  assign mem_addr_o      = (rst_n & req_c) ? {exmem_mem_addr_i[31:2], 2'b00} : '0;
  assign mem_be_o        = (rst_n & req_c) ? lane_be : '0;
  assign mem_wdata_o     = (rst_n & req_c) ? lane_wdata : '0;

  assign mem_reg_wdata_o = rst_n ? reg_wdata_c : '0;
  assign mem_reg_waddr_o = rst_n ? exmem_reg_waddr_i : '0;
  assign mem_reg_we_o    = rst_n & reg_we_c;
  assign mem_csr_wdata_o = rst_n ? exmem_csr_wdata_i : '0;
  assign mem_csr_waddr_o = rst_n ? exmem_csr_waddr_i : '0;
  assign mem_csr_we_o    = rst_n & csr_we_c;
  assign mem_stall_req_o = rst_n & stall_c;
  assign mem_exc_o       = rst_n & exc_c;
  assign mem_exc_code_o  = rst_n ? code_c : EXC_NONE;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// loads/stores checked against a cycle-count/arithmetic reference model.
module tb_mem_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] exmem_reg_wdata;
  logic [4:0]  exmem_reg_waddr;
  logic        exmem_reg_we;
  logic [31:0] exmem_csr_wdata;
  logic [11:0] exmem_csr_waddr;
  logic        exmem_csr_we;
  logic        exmem_mtype;
  logic        exmem_mem_rw;
  logic [1:0]  exmem_mem_width;
  logic [31:0] exmem_mem_addr;
  logic        exmem_mem_rdtype;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;

  logic        mem_req, mem_we, reg_we, csr_we, stall, exc;
  logic [31:0] mem_addr, mem_wdata, reg_wdata, csr_wdata;
  logic [3:0]  mem_be;
  logic [4:0]  reg_waddr;
  logic [11:0] csr_waddr;
  logic [1:0]  exc_code;

  logic        t_req, t_we, t_reg_we, t_csr_we, t_stall, t_exc;
  logic [31:0] t_addr, t_wdata, t_reg_wdata, t_csr_wdata;
  logic [3:0]  t_be;
  logic [4:0]  t_reg_waddr;
  logic [11:0] t_csr_waddr;
  logic [1:0]  t_code;

  int checks = 0;
  int errors = 0;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n),
    .exmem_reg_wdata_i(exmem_reg_wdata), .exmem_reg_waddr_i(exmem_reg_waddr),
    .exmem_reg_we_i(exmem_reg_we), .exmem_csr_wdata_i(exmem_csr_wdata),
    .exmem_csr_waddr_i(exmem_csr_waddr), .exmem_csr_we_i(exmem_csr_we),
    .exmem_mtype_i(exmem_mtype), .exmem_mem_rw_i(exmem_mem_rw),
    .exmem_mem_width_i(exmem_mem_width), .exmem_mem_addr_i(exmem_mem_addr),
    .exmem_mem_rdtype_i(exmem_mem_rdtype),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
    .mem_reg_wdata_o(reg_wdata), .mem_reg_waddr_o(reg_waddr), .mem_reg_we_o(reg_we),
    .mem_csr_wdata_o(csr_wdata), .mem_csr_waddr_o(csr_waddr), .mem_csr_we_o(csr_we),
    .mem_stall_req_o(stall), .mem_exc_o(exc), .mem_exc_code_o(exc_code)
  );

  mem_stage #(.TIMEOUT_CYC(4)) u_tmo (
    .clk(clk), .rst_n(rst_n),
    .exmem_reg_wdata_i(exmem_reg_wdata), .exmem_reg_waddr_i(exmem_reg_waddr),
    .exmem_reg_we_i(exmem_reg_we), .exmem_csr_wdata_i(exmem_csr_wdata),
    .exmem_csr_waddr_i(exmem_csr_waddr), .exmem_csr_we_i(exmem_csr_we),
    .exmem_mtype_i(exmem_mtype), .exmem_mem_rw_i(exmem_mem_rw),
    .exmem_mem_width_i(exmem_mem_width), .exmem_mem_addr_i(exmem_mem_addr),
    .exmem_mem_rdtype_i(exmem_mem_rdtype),
    .mem_req_o(t_req), .mem_we_o(t_we), .mem_addr_o(t_addr),
    .mem_be_o(t_be), .mem_wdata_o(t_wdata),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
    .mem_reg_wdata_o(t_reg_wdata), .mem_reg_waddr_o(t_reg_waddr), .mem_reg_we_o(t_reg_we),
    .mem_csr_wdata_o(t_csr_wdata), .mem_csr_waddr_o(t_csr_waddr), .mem_csr_we_o(t_csr_we),
    .mem_stall_req_o(t_stall), .mem_exc_o(t_exc), .mem_exc_code_o(t_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // Runs one EX/MEM instruction on the main DUT, acting as the bus slave.
  // Starts just after a rising edge; ends just after the edge that leaves the final cycle.
  task automatic run_txn(input logic rw, input logic [1:0] width, input logic [31:0] addr,
                         input logic [31:0] data, input logic rdtype, input logic we,
                         input logic [31:0] rdata, input logic err, input int gdelay, input int rdelay,
                         output int n_req, output int n_stall, output logic [31:0] o_addr,
                         output logic [3:0] o_be, output logic [31:0] o_wdata, output logic o_we,
                         output logic stable, output logic fin, output logic [31:0] f_wdata,
                         output logic f_we, output logic f_exc, output logic [1:0] f_code);
    int wcnt;
    n_req = 0; n_stall = 0; stable = 1'b1; fin = 1'b0; wcnt = 0;
    o_addr = '0; o_be = '0; o_wdata = '0; o_we = 1'b0;
    f_wdata = '0; f_we = 1'b0; f_exc = 1'b0; f_code = 2'b00;
    exmem_mtype = 1'b1; exmem_mem_rw = rw; exmem_mem_width = width; exmem_mem_addr = addr;
    exmem_reg_wdata = data; exmem_mem_rdtype = rdtype; exmem_reg_we = we; exmem_reg_waddr = 5'd7;
    exmem_csr_we = 1'b0; exmem_csr_wdata = '0; exmem_csr_waddr = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mem_req) begin
        if (n_req == 0) begin
          o_addr = mem_addr; o_be = mem_be; o_wdata = mem_wdata; o_we = mem_we;
        end else if (mem_addr !== o_addr || mem_be !== o_be || mem_wdata !== o_wdata || mem_we !== o_we) begin
          stable = 1'b0;
        end
        n_req++;
      end
      if (!stall) begin
        fin = 1'b1; f_wdata = reg_wdata; f_we = reg_we; f_exc = exc; f_code = exc_code;
        break;
      end
      n_stall++;
      if (mem_req) begin
        if (n_req - 1 == gdelay) mem_gnt = 1'b1;
      end else begin
        if (wcnt == rdelay) begin
          mem_rvalid = 1'b1; mem_rdata = rdata; mem_err = err;
        end
        wcnt++;
      end
      @(posedge clk); #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = $urandom;
    end
    @(posedge clk); #1;
    exmem_mtype = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0;
  endtask

  int nq, ns;
  logic [31:0] oa, ow, fw;
  logic [3:0]  ob;
  logic        owe, st, fn, fwe, fe;
  logic [1:0]  fc;

  task automatic test_reset();
    rst_n = 1'b0;
    exmem_mtype = 1'b1; exmem_mem_rw = 1'b0; exmem_mem_width = 2'b10; exmem_mem_addr = 32'h100;
    exmem_reg_wdata = 32'hDEADBEEF; exmem_reg_we = 1'b1; exmem_reg_waddr = 5'd3;
    exmem_csr_wdata = 32'h1234; exmem_csr_waddr = 12'h300; exmem_csr_we = 1'b1;
    exmem_mem_rdtype = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL reset_req_stall: got req=%b stall=%b, want 0 0", mem_req, stall); end
    checks++; if (reg_wdata !== 32'h0 || reg_we !== 1'b0 || csr_we !== 1'b0) begin errors++; $display("FAIL reset_outputs: got wdata=%h we=%b csr_we=%b, want zeros", reg_wdata, reg_we, csr_we); end
    checks++; if (exc !== 1'b0 || exc_code !== 2'b00) begin errors++; $display("FAIL reset_exc: got %b/%b, want 0/00", exc, exc_code); end
    exmem_mtype = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    checks++; if (reg_wdata !== 32'hDEADBEEF || reg_we !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL reset_release_pass: got %h we=%b stall=%b, want DEADBEEF 1 0", reg_wdata, reg_we, stall); end
    @(posedge clk); #1;
  endtask

  task automatic test_lb();
    run_txn(1'b0, 2'b00, 32'h103, 32'h103, 1'b0, 1'b1, 32'h80FF_0000, 1'b0, 0, 0,
            nq, ns, oa, ob, ow, owe, st, fn, fw, fwe, fe, fc);
    checks++; if (oa !== 32'h100 || ob !== 4'b1111 || owe !== 1'b0) begin errors++; $display("FAIL lb_bus: got addr=%h be=%b we=%b, want 100 1111 0", oa, ob, owe); end
    checks++; if (ns !== 2 || fn !== 1'b1) begin errors++; $display("FAIL lb_stall: got %0d cycles fin=%b, want 2 1", ns, fn); end
    checks++; if (fw !== 32'hFFFF_FF80 || fwe !== 1'b1 || fe !== 1'b0) begin errors++; $display("FAIL lb_result: got %h we=%b exc=%b, want FFFFFF80 1 0", fw, fwe, fe); end
  endtask

  task automatic test_lhu();
    run_txn(1'b0, 2'b01, 32'h202, 32'h202, 1'b1, 1'b1, 32'h9ABC_1234, 1'b0, 0, 1,
            nq, ns, oa, ob, ow, owe, st, fn, fw, fwe, fe, fc);
    checks++; if (fw !== 32'h0000_9ABC || ns !== 3) begin errors++; $display("FAIL lhu_result: got %h stall=%0d, want 00009ABC 3", fw, ns); end
    run_txn(1'b0, 2'b01, 32'h202, 32'h202, 1'b0, 1'b1, 32'h9ABC_1234, 1'b0, 1, 0,
            nq, ns, oa, ob, ow, owe, st, fn, fw, fwe, fe, fc);
    checks++; if (fw !== 32'hFFFF_9ABC) begin errors++; $display("FAIL lh_result: got %h, want FFFF9ABC", fw); end
  endtask

  task automatic test_sb();
    run_txn(1'b1, 2'b00, 32'h301, 32'h0000_00A5, 1'b0, 1'b0, 32'h0, 1'b0, 3, 0,
            nq, ns, oa, ob, ow, owe, st, fn, fw, fwe, fe, fc);
    checks++; if (nq !== 4 || st !== 1'b1) begin errors++; $display("FAIL sb_req_hold: got %0d cycles stable=%b, want 4 1", nq, st); end
    checks++; if (ob !== 4'b0010 || ow !== 32'hA5A5_A5A5 || owe !== 1'b1 || oa !== 32'h300) begin errors++; $display("FAIL sb_bus: got be=%b wdata=%h we=%b addr=%h, want 0010 A5A5A5A5 1 300", ob, ow, owe, oa); end
    checks++; if (fwe !== 1'b0 || fe !== 1'b0 || fn !== 1'b1) begin errors++; $display("FAIL sb_done: got we=%b exc=%b fin=%b, want 0 0 1", fwe, fe, fn); end
  endtask

  task automatic test_misaligned();
    run_txn(1'b0, 2'b10, 32'h402, 32'h402, 1'b0, 1'b1, 32'h0, 1'b0, 0, 0,
            nq, ns, oa, ob, ow, owe, st, fn, fw, fwe, fe, fc);
    checks++; if (nq !== 0 || ns !== 0) begin errors++; $display("FAIL misalign_noreq: got req=%0d stall=%0d, want 0 0", nq, ns); end
    checks++; if (fe !== 1'b1 || fc !== 2'b01 || fwe !== 1'b0) begin errors++; $display("FAIL misalign_exc: got exc=%b code=%b we=%b, want 1 01 0", fe, fc, fwe); end
  endtask

  task automatic test_bus_err();
    run_txn(1'b0, 2'b10, 32'h400, 32'h400, 1'b0, 1'b1, 32'h5555_AAAA, 1'b1, 0, 1,
            nq, ns, oa, ob, ow, owe, st, fn, fw, fwe, fe, fc);
    checks++; if (fe !== 1'b1 || fc !== 2'b10 || fwe !== 1'b0) begin errors++; $display("FAIL bus_err: got exc=%b code=%b we=%b, want 1 10 0", fe, fc, fwe); end
  endtask

  task automatic test_back_to_back();
    run_txn(1'b0, 2'b10, 32'h500, 32'h500, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 0, 0,
            nq, ns, oa, ob, ow, owe, st, fn, fw, fwe, fe, fc);
    checks++; if (fw !== 32'h1234_5678 || fwe !== 1'b1) begin errors++; $display("FAIL b2b_load: got %h we=%b, want 12345678 1", fw, fwe); end
    exmem_reg_wdata = 32'hCAFE_0001; exmem_reg_we = 1'b1; exmem_reg_waddr = 5'd9;
    exmem_csr_wdata = 32'h0BAD_F00D; exmem_csr_waddr = 12'h341; exmem_csr_we = 1'b1;
    @(negedge clk);
    checks++; if (stall !== 1'b0 || mem_req !== 1'b0 || exc !== 1'b0) begin errors++; $display("FAIL b2b_nostall: got stall=%b req=%b exc=%b, want 0 0 0", stall, mem_req, exc); end
    checks++; if (reg_wdata !== 32'hCAFE_0001 || reg_we !== 1'b1 || reg_waddr !== 5'd9) begin errors++; $display("FAIL b2b_reg: got %h we=%b rd=%0d, want CAFE0001 1 9", reg_wdata, reg_we, reg_waddr); end
    checks++; if (csr_wdata !== 32'h0BAD_F00D || csr_waddr !== 12'h341 || csr_we !== 1'b1) begin errors++; $display("FAIL b2b_csr: got %h %h we=%b, want 0BADF00D 341 1", csr_wdata, csr_waddr, csr_we); end
    @(posedge clk); #1;
    exmem_csr_we = 1'b0;
  endtask

  task automatic test_random();
    logic rw, rdt, we, err, bad;
    logic [1:0] w, a;
    logic [31:0] addr, data, rdata, sh, e_res, e_wd;
    logic [3:0] e_be;
    int gd, rd, e_stall, e_req;
    for (int i = 0; i < 40; i++) begin
      rw = 1'($urandom); rdt = 1'($urandom); we = 1'($urandom);
      err = ($urandom_range(0, 7) == 0);
      w = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      addr = $urandom; data = $urandom; rdata = $urandom;
      gd = $urandom_range(0, 3); rd = $urandom_range(0, 3);
      a = addr[1:0];
      bad = (w == 2'b11) || (w == 2'b01 && a[0]) || (w == 2'b10 && a != 2'b00);
      sh = rdata >> (8 * a);
      if (w == 2'b00) begin
        e_res = sh & 32'hFF;
        if (!rdt && e_res[7]) e_res = e_res | 32'hFFFF_FF00;
        e_be = 4'(1 << a); e_wd = 32'h0101_0101 * {24'd0, data[7:0]};
      end else if (w == 2'b01) begin
        e_res = sh & 32'hFFFF;
        if (!rdt && e_res[15]) e_res = e_res | 32'hFFFF_0000;
        e_be = 4'(3 << a); e_wd = 32'h0001_0001 * {16'd0, data[15:0]};
      end else begin
        e_res = rdata; e_be = 4'hF; e_wd = data;
      end
      if (!rw) begin e_be = 4'hF; e_wd = 32'h0; end
      if (rw) e_res = data;
      e_req   = bad ? 0 : gd + 1;
      e_stall = bad ? 0 : gd + rd + 2;
      run_txn(rw, w, addr, data, rdt, we, rdata, err, gd, rd,
              nq, ns, oa, ob, ow, owe, st, fn, fw, fwe, fe, fc);
      checks++; if (fn !== 1'b1 || ns !== e_stall || nq !== e_req) begin errors++; $display("FAIL rnd%0d_timing: got fin=%b stall=%0d req=%0d, want 1 %0d %0d", i, fn, ns, nq, e_stall, e_req); end
      if (bad) begin
        checks++; if (fe !== 1'b1 || fc !== 2'b01 || fwe !== 1'b0 || fw !== data) begin errors++; $display("FAIL rnd%0d_bad: got exc=%b code=%b we=%b wdata=%h, want 1 01 0 %h", i, fe, fc, fwe, fw, data); end
      end else begin
        checks++; if (oa !== {addr[31:2], 2'b00} || ob !== e_be || owe !== rw || st !== 1'b1) begin errors++; $display("FAIL rnd%0d_bus: got addr=%h be=%b we=%b stable=%b, want %h %b %b 1", i, oa, ob, owe, st, {addr[31:2], 2'b00}, e_be, rw); end
        if (rw) begin
          checks++; if (ow !== e_wd) begin errors++; $display("FAIL rnd%0d_wdata: got %h, want %h", i, ow, e_wd); end
        end
        checks++; if (fe !== err || fwe !== (we & ~err) || (err && fc !== 2'b10)) begin errors++; $display("FAIL rnd%0d_done: got exc=%b code=%b we=%b, want %b 10 %b", i, fe, fc, fwe, err, we & ~err); end
        checks++; if (fw !== e_res) begin errors++; $display("FAIL rnd%0d_result: got %h, want %h", i, fw, e_res); end
      end
    end
  endtask

  task automatic test_reset_in_wait();
    exmem_mtype = 1'b1; exmem_mem_rw = 1'b0; exmem_mem_width = 2'b10; exmem_mem_addr = 32'h700;
    exmem_reg_wdata = 32'h700; exmem_reg_we = 1'b1; exmem_mem_rdtype = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_wait_req: got %b, want 1", mem_req); end
    mem_gnt = 1'b1;
    @(posedge clk); #1; mem_gnt = 1'b0;
    @(negedge clk);
    checks++; if (stall !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL rst_wait_state: got stall=%b req=%b, want 1 0", stall, mem_req); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (stall !== 1'b0 || mem_req !== 1'b0 || reg_we !== 1'b0) begin errors++; $display("FAIL rst_wait_async: got stall=%b req=%b we=%b, want 0 0 0", stall, mem_req, reg_we); end
    exmem_mtype = 1'b0; exmem_reg_wdata = 32'h0000_0777;
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    checks++; if (stall !== 1'b0 || mem_req !== 1'b0 || reg_wdata !== 32'h777) begin errors++; $display("FAIL rst_wait_idle: got stall=%b req=%b wdata=%h, want 0 0 777", stall, mem_req, reg_wdata); end
    @(posedge clk); #1;
    run_txn(1'b0, 2'b00, 32'h103, 32'h103, 1'b0, 1'b1, 32'h80FF_0000, 1'b0, 0, 0,
            nq, ns, oa, ob, ow, owe, st, fn, fw, fwe, fe, fc);
    checks++; if (ns !== 2 || fw !== 32'hFFFF_FF80) begin errors++; $display("FAIL rst_wait_after: got stall=%0d res=%h, want 2 FFFFFF80", ns, fw); end
  endtask

  task automatic test_timeout();
    int tcnt, rcnt;
    logic done_seen, d_exc, d_we;
    logic [1:0] d_code;
    tcnt = 0; rcnt = 0; done_seen = 1'b0; d_exc = 1'b0; d_we = 1'b1; d_code = 2'b00;
    exmem_mtype = 1'b1; exmem_mem_rw = 1'b0; exmem_mem_width = 2'b10; exmem_mem_addr = 32'h600;
    exmem_reg_wdata = 32'h600; exmem_reg_we = 1'b1;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (t_req) rcnt++;
      if (!t_stall) begin
        done_seen = 1'b1; d_exc = t_exc; d_code = t_code; d_we = t_reg_we;
        break;
      end
      tcnt++;
    end
    checks++; if (done_seen !== 1'b1 || tcnt !== 4 || rcnt !== 4) begin errors++; $display("FAIL tmo_cycles: got done=%b stall=%0d req=%0d, want 1 4 4", done_seen, tcnt, rcnt); end
    checks++; if (d_exc !== 1'b1 || d_code !== 2'b11 || d_we !== 1'b0) begin errors++; $display("FAIL tmo_exc: got exc=%b code=%b we=%b, want 1 11 0", d_exc, d_code, d_we); end
    @(posedge clk); #1;
    exmem_mtype = 1'b0; exmem_reg_wdata = 32'h0000_0055;
    @(negedge clk);
    mem_rvalid = 1'b1; mem_err = 1'b1;
    @(posedge clk); #1; mem_rvalid = 1'b0; mem_err = 1'b0;
    @(negedge clk);
    checks++; if (t_stall !== 1'b0 || t_exc !== 1'b0 || t_reg_wdata !== 32'h55 || t_reg_we !== 1'b1) begin errors++; $display("FAIL tmo_late_rvalid: got stall=%b exc=%b wdata=%h we=%b, want 0 0 55 1", t_stall, t_exc, t_reg_wdata, t_reg_we); end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_lhu();
    test_sb();
    test_misaligned();
    test_bus_err();
    test_back_to_back();
    test_random();
    test_reset_in_wait();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
